// File: rtl/count_checker_pkg.sv
// Shared types, defaults and helpers for the up/down counter-pair checker.
package count_checker_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int ERRW_DEF  = 8;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_CHECK = 2'd1,
      ST_ERR   = 2'd2
   } state_e;

   // Increment that sticks at max_value instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
      if (value >= max_value) begin
         sat_inc = max_value;
      end else begin
         sat_inc = value + 32'd1;
      end
   endfunction

endpackage

// File: rtl/count_predict.sv
// Next-value model of the observed up/down counter pair; swap overrides enable.
module count_predict #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] up_i,
   input  logic [WIDTH-1:0] down_i,
   input  logic             en_i,
   input  logic             swap_i,
   output logic [WIDTH-1:0] up_o,
   output logic [WIDTH-1:0] down_o
);

   // Wrap-around is natural modulo-2^WIDTH arithmetic.
   always_comb begin
      up_o   = up_i;
      down_o = down_i;
      if (swap_i) begin
         up_o   = down_i;
         down_o = up_i;
      end else if (en_i) begin
         up_o   = up_i + WIDTH'(1'b1);
         down_o = down_i - WIDTH'(1'b1);
      end else begin
         up_o   = up_i;
         down_o = down_i;
      end
   end

endmodule

// File: rtl/count_checker.sv
// Watches an up/down counter pair, predicts each next value from the previous
// sample and reports mismatches through a SYNC/CHECK/ERR state machine.
module count_checker
   import count_checker_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int ERRW  = ERRW_DEF
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             Swap,
   input  logic [WIDTH-1:0] UpCountS,
   input  logic [WIDTH-1:0] DownCountS,
   input  logic             Clear,
   output logic             Ok,
   output logic             ErrorFlag,
   output logic [ERRW-1:0]  ErrorCount,
   output logic [ERRW-1:0]  SwapCount,
   output logic [1:0]       State
);

   localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] prev_up_q, prev_up_d;
   logic [WIDTH-1:0] prev_down_q, prev_down_d;
   logic             prev_en_q, prev_en_d;
   logic             prev_swap_q, prev_swap_d;
   logic             ok_q, ok_d;
   logic             err_flag_q, err_flag_d;
   logic [ERRW-1:0]  err_cnt_q, err_cnt_d;
   logic [ERRW-1:0]  swap_cnt_q, swap_cnt_d;

   logic [WIDTH-1:0] pred_up_s;
   logic [WIDTH-1:0] pred_down_s;
   logic             mismatch_s;
   logic             compare_s;

   count_predict #(.WIDTH(WIDTH)) u_predict (
      .up_i   (prev_up_q),
      .down_i (prev_down_q),
      .en_i   (prev_en_q),
      .swap_i (prev_swap_q),
      .up_o   (pred_up_s),
      .down_o (pred_down_s)
   );

   assign mismatch_s = (UpCountS != pred_up_s) || (DownCountS != pred_down_s);
   assign compare_s  = (state_q == ST_CHECK) || (state_q == ST_ERR);

   // Next-state, error history and swap-edge counting; Clear beats any mismatch.
   always_comb begin
      prev_up_d   = UpCountS;
      prev_down_d = DownCountS;
      prev_en_d   = Enable;
      prev_swap_d = Swap;
      state_d     = state_q;
      err_flag_d  = err_flag_q;
      err_cnt_d   = err_cnt_q;

      if (Swap && !prev_swap_q) begin
         swap_cnt_d = swap_cnt_q + ERRW'(1'b1);
      end else begin
         swap_cnt_d = swap_cnt_q;
      end

      if (Clear) begin
         state_d    = ST_SYNC;
         err_flag_d = 1'b0;
         err_cnt_d  = '0;
      end else begin
         case (state_q)
            ST_SYNC:  state_d = ST_CHECK;
            ST_CHECK: begin
               if (mismatch_s) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_CHECK;
               end
            end
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_SYNC;
         endcase

         if (compare_s && mismatch_s) begin
            err_flag_d = 1'b1;
            err_cnt_d  = ERRW'(sat_inc(32'(err_cnt_q), 32'(ERR_MAX)));
         end else begin
            err_flag_d = err_flag_q;
            err_cnt_d  = err_cnt_q;
         end
      end

      ok_d = (state_d == ST_CHECK);
   end

   // All state, with synchronous active-low reset taking priority.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q     <= ST_SYNC;
         prev_up_q   <= '0;
         prev_down_q <= '0;
         prev_en_q   <= 1'b0;
         prev_swap_q <= 1'b0;
         ok_q        <= 1'b0;
         err_flag_q  <= 1'b0;
         err_cnt_q   <= '0;
         swap_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         prev_up_q   <= prev_up_d;
         prev_down_q <= prev_down_d;
         prev_en_q   <= prev_en_d;
         prev_swap_q <= prev_swap_d;
         ok_q        <= ok_d;
         err_flag_q  <= err_flag_d;
         err_cnt_q   <= err_cnt_d;
         swap_cnt_q  <= swap_cnt_d;
      end
   end

   assign Ok         = ok_q;
   assign ErrorFlag  = err_flag_q;
   assign ErrorCount = err_cnt_q;
   assign SwapCount  = swap_cnt_q;
   assign State      = state_q;

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker: stimulus pushes expected outputs from a
// behavioural model, a monitor pops and compares after every clock edge.
module tb_count_checker;

   logic       Clock = 1'b0;
   logic       Reset, Enable, Swap, Clear;
   logic [3:0] UpCountS, DownCountS;
   logic       Ok, ErrorFlag;
   logic [7:0] ErrorCount, SwapCount;
   logic [1:0] State;

   always #5 Clock = ~Clock;

   count_checker #(.WIDTH(4), .ERRW(8)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Enable     (Enable),
      .Swap       (Swap),
      .UpCountS   (UpCountS),
      .DownCountS (DownCountS),
      .Clear      (Clear),
      .Ok         (Ok),
      .ErrorFlag  (ErrorFlag),
      .ErrorCount (ErrorCount),
      .SwapCount  (SwapCount),
      .State      (State)
   );

   typedef struct packed {
      logic [1:0] st;
      logic       ok;
      logic       flag;
      logic [7:0] errs;
      logic [7:0] swaps;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: "have we got a reference sample", "have we seen an error".
   bit m_checking, m_failed, m_flag, m_last_swap;
   int m_errs, m_swaps, m_pred_up, m_pred_down;

   task automatic model_edge(input bit rst, input bit clr, input bit en, input bit sw,
                             input int up, input int down);
      exp_t e;
      bit   mism;
      if (!rst) begin
         m_checking = 1'b0; m_failed = 1'b0; m_flag = 1'b0;
         m_errs = 0; m_swaps = 0;
         m_pred_up = 0; m_pred_down = 0; m_last_swap = 1'b0;
      end else begin
         mism = m_checking && (up != m_pred_up || down != m_pred_down);
         if (sw && !m_last_swap) m_swaps = (m_swaps + 1) % 256;
         if (clr) begin
            m_checking = 1'b0; m_failed = 1'b0; m_flag = 1'b0; m_errs = 0;
         end else if (!m_checking) begin
            m_checking = 1'b1;
         end else if (mism) begin
            m_failed = 1'b1; m_flag = 1'b1;
            if (m_errs < 255) m_errs = m_errs + 1;
         end
         if (sw) begin
            m_pred_up = down; m_pred_down = up;
         end else if (en) begin
            m_pred_up = (up + 1) % 16; m_pred_down = (down + 15) % 16;
         end else begin
            m_pred_up = up; m_pred_down = down;
         end
         m_last_swap = sw;
      end
      e.st    = !m_checking ? 2'd0 : (m_failed ? 2'd2 : 2'd1);
      e.ok    = m_checking && !m_failed;
      e.flag  = m_flag;
      e.errs  = 8'(m_errs);
      e.swaps = 8'(m_swaps);
      exp_q.push_back(e);
   endtask

   // Stimulus-side counter: last values actually driven.
   int cur_up = 0, cur_down = 0;
   bit last_en = 1'b0, last_sw = 1'b0;

   task automatic drive(input bit rst, input bit clr, input bit en, input bit sw,
                        input int up, input int down);
      Reset = rst; Clear = clr; Enable = en; Swap = sw;
      UpCountS = 4'(up); DownCountS = 4'(down);
      model_edge(rst, clr, en, sw, up, down);
      cur_up = up; cur_down = down; last_en = en; last_sw = sw;
      @(negedge Clock);
   endtask

   // Present the value a healthy counter would show now, optionally corrupted.
   task automatic step(input bit en, input bit sw, input bit corrupt, input bit clr);
      int up, down;
      if (last_sw) begin
         up = cur_down; down = cur_up;
      end else if (last_en) begin
         up = (cur_up + 1) % 16; down = (cur_down + 15) % 16;
      end else begin
         up = cur_up; down = cur_down;
      end
      if (corrupt) up = up ^ 1;
      drive(1'b1, clr, en, sw, up, down);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge Clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("State",      {6'd0, State},     {6'd0, e.st});
            chk("Ok",         {7'd0, Ok},        {7'd0, e.ok});
            chk("ErrorFlag",  {7'd0, ErrorFlag}, {7'd0, e.flag});
            chk("ErrorCount", ErrorCount,        e.errs);
            chk("SwapCount",  SwapCount,         e.swaps);
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

      // Clean counting through the wrap points, starting with the capture edge.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 15);
      repeat (19) step(1'b1, 1'b0, 1'b0, 1'b0);

      // Swap pulse at Up=5/Down=10.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);

      repeat (150) step($urandom_range(1, 0) == 1, $urandom_range(4, 0) == 0, 1'b0, 1'b0);

      // Resync, capture 5/3, then Up=7 where 6 is predicted, and two more bad cycles.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 5, 3);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);

      // Saturation, then Clear coincident with a mismatch.
      repeat (300) step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1);

      repeat (300) step($urandom_range(1, 0) == 1, $urandom_range(5, 0) == 0,
                        $urandom_range(24, 0) == 0, $urandom_range(39, 0) == 0);

      // Force ERR with swaps recorded, then reset mid-operation.
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 3, 9);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 2, 2);
      repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);

      @(negedge Clock);
      chk("scoreboard_drain", 8'(exp_q.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
